// File: rtl/l2_line_burst_adaptor.sv
// l2_line_burst_adaptor
// Bridges 256-bit L2 line reads/writes onto a 4-beat x 64-bit memory burst
// interface. Write-back lines are serialised beat by beat; fill lines are
// assembled from returned beats. Each request completes with a one-cycle
// pmem_resp.
module l2_line_burst_adaptor (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [255:0] pmem_wdata,
    output logic [255:0] pmem_rdata,
    output logic         pmem_resp,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [63:0]  burst_o,
    input  logic [63:0]  burst_i,
    input  logic         resp_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_reg;
    logic [1:0]     cnt_reg;
    logic [255:0]   line_reg;

    // Line buffer with the incoming beat merged into slot cnt_reg.
    logic [255:0]   fill_next;
    // Line buffer viewed as four 64-bit beats for write serialisation.
    logic [63:0]    beat_sel [4];

    // The low address bits select a byte within the line and are dropped.
    logic           unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[4:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_beat
            assign fill_next[64*gi +: 64] = (cnt_reg == 2'(gi)) ? burst_i
                                                                 : line_reg[64*gi +: 64];
            assign beat_sel[gi] = line_reg[64*gi +: 64];
        end
    endgenerate

    // Request sequencing, beat counting and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 2'd0;
            line_reg   <= '0;
            pmem_rdata <= '0;
            pmem_resp  <= 1'b0;
            address_o  <= '0;
            read_o     <= 1'b0;
            write_o    <= 1'b0;
            burst_o    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    pmem_resp <= 1'b0;
                    // A write wins over a simultaneous read; the L2 re-requests the read.
                    if (pmem_write) begin
                        address_o <= {pmem_address[31:5], 5'b0};
                        line_reg  <= pmem_wdata;
                        burst_o   <= pmem_wdata[63:0];
                        write_o   <= 1'b1;
                        cnt_reg   <= 2'd0;
                        state_reg <= WR;
                    end else if (pmem_read) begin
                        address_o <= {pmem_address[31:5], 5'b0};
                        read_o    <= 1'b1;
                        cnt_reg   <= 2'd0;
                        state_reg <= RD;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_reg <= fill_next;
                        cnt_reg  <= cnt_reg + 2'd1;
                        if (cnt_reg == 2'd3) begin
                            read_o     <= 1'b0;
                            pmem_resp  <= 1'b1;
                            pmem_rdata <= fill_next;
                            state_reg  <= DONE;
                        end
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt_reg <= cnt_reg + 2'd1;
                        if (cnt_reg == 2'd3) begin
                            write_o   <= 1'b0;
                            burst_o   <= '0;
                            pmem_resp <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            burst_o <= beat_sel[cnt_reg + 2'd1];
                        end
                    end
                end
                DONE: begin
                    // Requests still held this cycle are deliberately ignored.
                    pmem_resp <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_line_burst_adaptor.sv
// Testbench for l2_line_burst_adaptor: directed scenarios followed by
// randomized line traffic, checked by a scoreboard of expected line
// transactions and a memory model that serves/consumes beats.
module tb_l2_line_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i;
    logic         resp_i;

    l2_line_burst_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .burst_o      (burst_o),
        .burst_i      (burst_i),
        .resp_i       (resp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
    } txn_t;

    txn_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    // 0: no gaps, 1: fixed pattern, 2: random gaps, 3: stop after 2 beats
    int   gap_mode = 0;
    int   mem_k = 0;
    logic [255:0] last_rd = '0;
    bit   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    // Memory model: checks the burst request against the front transaction,
    // returns read beats / consumes write beats with the selected gap pattern.
    initial begin
        int  c;
        bit  r;
        txn_t e;
        c = 0;
        resp_i = 1'b0;
        burst_i = '0;
        forever begin
            @(negedge clk);
            if (rst || !(read_o || write_o)) begin
                resp_i = 1'b0;
                mem_k  = 0;
                c      = 0;
            end else if (exp_q.size() == 0) begin
                chk("burst_without_request", {254'd0, read_o, write_o}, 256'd0);
                resp_i = 1'b0;
            end else begin
                e = exp_q[0];
                chk("address_o", address_o, e.addr);
                chk("read_o", read_o, !e.is_wr);
                chk("write_o", write_o, e.is_wr);
                if (mem_k > 3) begin
                    chk("burst_too_long", mem_k, 3);
                    resp_i = 1'b0;
                end else begin
                    if (write_o) chk("burst_o", burst_o, e.line[64*mem_k +: 64]);
                    case (gap_mode)
                        0:       r = 1'b1;
                        1:       r = (c < 7) ? pat[c] : 1'b1;
                        2:       r = ($urandom_range(0, 9) < 7);
                        default: r = (mem_k < 2);
                    endcase
                    resp_i  = r;
                    burst_i = r ? e.line[64*mem_k +: 64] : {$urandom, $urandom};
                    if (r) mem_k++;
                    c++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each completion and checks the fill line.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rd = '0;
            end else if (pmem_resp) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pmem_resp", pmem_resp, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_wr) begin
                        chk("pmem_rdata_fill", pmem_rdata, e.line);
                        last_rd = e.line;
                    end else begin
                        chk("pmem_rdata_after_write", pmem_rdata, last_rd);
                    end
                    $display("txn %s addr=%h done", e.is_wr ? "WR" : "RD", e.addr);
                end
            end else begin
                chk("pmem_rdata_hold", pmem_rdata, last_rd);
            end
        end
    end

    // Raise a request in the next cycle and wait for its pmem_resp; returns at
    // the negedge of the pmem_resp cycle with the request still asserted.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [255:0] line, output int lat);
        txn_t e;
        @(negedge clk);
        pmem_address = addr;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_wdata   = wr ? line : rand_line();
        e.is_wr = wr;
        e.addr  = {addr[31:5], 5'b0};
        e.line  = line;
        exp_q.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!pmem_resp && lat < 100);
        if (!pmem_resp) chk("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic release_req();
        @(negedge clk);
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        logic [255:0] l;
        rst = 1'b1;
        pmem_address = 32'h0;
        pmem_read = 1'b1;
        pmem_write = 1'b0;
        pmem_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_pmem_resp", pmem_resp, 1'b0);
        chk("rst_pmem_rdata", pmem_rdata, 256'd0);
        chk("rst_address_o", address_o, 32'd0);
        chk("rst_burst_o", burst_o, 64'd0);
        pmem_read = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Read with no gaps: known beats, pulse 5 cycles after acceptance.
        gap_mode = 0;
        l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_req(1'b1, 1'b0, 32'h0000_1234, l, lat);
        chk("read_latency", lat, 5);
        release_req();

        // Write with resp_i pattern 1,0,0,1,1,0,1.
        gap_mode = 1;
        do_req(1'b0, 1'b1, 32'h8000_0040, rand_line(), lat);
        chk("write_gap_latency", lat, 8);
        release_req();

        // Simultaneous read and write: write wins.
        gap_mode = 0;
        do_req(1'b1, 1'b1, 32'h0000_2000, rand_line(), lat);
        chk("simul_latency", lat, 5);
        release_req();
        @(negedge clk);
        chk("simul_no_read", read_o, 1'b0);

        // Mid-burst reset after 2 read beats.
        gap_mode = 3;
        @(negedge clk);
        pmem_address = 32'h0000_3000;
        pmem_read = 1'b1;
        exp_q.push_back('{1'b0, 32'h0000_3000, rand_line()});
        n = 0;
        while (mem_k < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("abort_two_beats", mem_k, 2);
        @(negedge clk);
        rst = 1'b1;
        pmem_read = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_read_o", read_o, 1'b0);
        chk("abort_no_resp", pmem_resp, 1'b0);
        chk("abort_rdata", pmem_rdata, 256'd0);
        gap_mode = 2;
        do_req(1'b1, 1'b0, 32'h0000_3000, rand_line(), lat);
        release_req();

        // Back-to-back write then read.
        gap_mode = 0;
        do_req(1'b0, 1'b1, 32'h0000_4020, rand_line(), lat);
        do_req(1'b1, 1'b0, 32'h0000_5000, rand_line(), lat);
        chk("b2b_read_latency", lat, 5);
        release_req();

        // Randomized traffic.
        gap_mode = 2;
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 2);
            do_req(op != 1, op != 0, $urandom, rand_line(), lat);
            if ($urandom_range(0, 1) == 0) release_req();
        end
        release_req();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_line_burst_adaptor.md
# l2_line_burst_adaptor

Responder for the L2 cache's physical-memory port: accepts 256-bit line reads and writes from the L2 datapath/controller and services them as four-beat 64-bit bursts on the DRAM-side interface. It sits between the L2 cache and main memory. It serialises write-back lines into beats, assembles fill lines from returned beats, and returns a single-cycle `pmem_resp` per request.

## Interface
Parameters:
- none. Line is 256 bits, beat is 64 bits, burst is 4 beats; all fixed.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pmem_address`  in  32  line address from the L2; sampled at request acceptance.
- `pmem_read`  in  1  line read request; level, held by L2 until `pmem_resp`.
- `pmem_write`  in  1  line write request; level, held by L2 until `pmem_resp`.
- `pmem_wdata`  in  256  write line; sampled at acceptance.
- `pmem_rdata`  out  256  assembled fill line; valid in the `pmem_resp` cycle, held until the next read completes.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `address_o`  out  32  burst address, always line-aligned: `{addr[31:5], 5'b0}`.
- `read_o`  out  1  burst read request.
- `write_o`  out  1  burst write request.
- `burst_o`  out  64  current write beat.
- `burst_i`  in  64  returned read beat, valid when `resp_i` is high.
- `resp_i`  in  1  beat strobe from memory; one beat transferred per high cycle.

## Operation
- States: IDLE, RD, WR, DONE. Registered outputs, 2-bit beat counter `cnt`, 256-bit line buffer.
- **IDLE:**
  - If `pmem_write`: latch the aligned address and `pmem_wdata`, set `cnt=0`, and go to WR.
  - Else if `pmem_read`: latch the aligned address, set `cnt=0`, and go to RD.
  - If both are high, the write wins. The read is serviced only after the L2 re-requests it.
  - `resp_i` is ignored in IDLE.
- **RD:**
  - `read_o=1` and `address_o` are held for the whole state.
  - On each `resp_i` cycle, store `burst_i` into buffer bits `[64*cnt+63 : 64*cnt]` and increment `cnt`.
  - On the beat with `cnt=3`, go to DONE and drop `read_o`. `cnt` wraps to 0.
- **WR:**
  - `write_o=1`, `address_o` held, and `burst_o` = buffer beat `cnt` (beat 0 = bits `[63:0]`).
  - On each `resp_i` cycle, increment `cnt`, so the next beat is presented the following cycle.
  - On the beat with `cnt=3`, go to DONE and drop `write_o`.
- **Gaps:** cycles with `resp_i` low between beats stall the counter. Gaps are allowed anywhere in the burst.
- **DONE:** `pmem_resp=1` for exactly this cycle; `pmem_rdata` drives the buffer; then go to IDLE. A request still high in the DONE cycle is not re-accepted.
- **Write completion:** a completed write does not change `pmem_rdata`.

## Timing
- **Reset values:** state IDLE, `cnt=0`, buffer 0; `pmem_resp`, `pmem_rdata`, `read_o`, `write_o`, `address_o`, `burst_o` all 0.
- **Reset mid-burst:** return to IDLE the next edge and drop all partial beats. The requester and memory are reset concurrently.
- **Acceptance:** request high in IDLE at edge t. `read_o`/`write_o` and `address_o` are valid from cycle t+1.
- **Earliest memory response:** `resp_i` may first be high in cycle t+1. With no gaps, beats land in cycles t+1..t+4 and `pmem_resp` pulses in t+5. Each gap cycle adds one cycle.
- **Write beat 0:** `burst_o` shows beat 0 in the first WR cycle and changes only on the edge after a `resp_i` cycle.
- **Request hold:** the L2 must deassert the request in the cycle after `pmem_resp`. The adaptor is in IDLE that cycle and accepts any new request present.
- **Throughput:** back-to-back requests have minimum spacing of 6 cycles (accept, 4 beats, DONE).

## Test plan
- **Reset:** assert `rst` 2 cycles -> all outputs 0, no `read_o`/`write_o` despite `pmem_read=1` during reset.
- **Read, no gaps:** read to 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> `address_o=0x0000_1220`, `pmem_rdata={44..,33..,22..,11..}`, `pmem_resp` single pulse 5 cycles after acceptance.
- **Write with gaps:** write line {D3,D2,D1,D0} to 0x8000_0040 with `resp_i` pattern 1,0,0,1,1,0,1 -> `burst_o` sequence D0,D1,D1,D1,D2,D3,D3, `write_o` drops and `pmem_resp` pulses after the 4th strobe.
- **Simultaneous request:** `pmem_read=pmem_write=1` in IDLE -> `write_o` asserted, `read_o` stays 0.
- **Mid-burst reset:** `rst` after 2 read beats -> IDLE, no `pmem_resp`. A subsequent read returns only the new beats.
- **Back-to-back:** write immediately followed by read -> the read is accepted in the cycle after `pmem_resp`, and `pmem_rdata` is unchanged until the read's DONE.
